// File: rtl/hps_alarm_timer.sv
// HPS alarm timer: commanded one-shot/periodic countdown on the shared tick base,
// raising a sticky level interrupt (with overrun flag) on each expiry.
module hps_alarm_timer #(
  parameter int TICK_DIV = 5000,
  parameter int WIDTH    = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_mode,
  input  logic [WIDTH-1:0] i_cmd_period,
  input  logic             i_irq_ack,
  output logic             o_irq,
  output logic             o_overrun,
  output logic [WIDTH-1:0] o_remaining,
  output logic             o_busy
);

  localparam int              PW   = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam logic [PW-1:0]   TDIV = PW'(TICK_DIV);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [PW-1:0]    r_presc;
  logic [WIDTH-1:0] r_remaining;
  logic [WIDTH-1:0] r_period;
  logic             r_periodic;
  logic             r_irq;
  logic             r_overrun;

  logic w_accept, w_stop, w_tick, w_expire;

  assign o_cmd_ready = (r_state != LOAD);
  assign o_busy      = (r_state != IDLE);
  assign o_remaining = r_remaining;
  assign o_irq       = r_irq;
  assign o_overrun   = r_overrun;

  assign w_accept = i_cmd_valid & o_cmd_ready;
  assign w_stop   = (i_cmd_mode == 2'b00) || (i_cmd_mode == 2'b11);
  assign w_tick   = (r_state == RUN) && (r_presc == TDIV);
  // A command accepted on the expiry edge pre-empts the expiry entirely.
  assign w_expire = w_tick && (r_remaining == ONE) && !w_accept;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = w_stop ? IDLE : LOAD;
    end else begin
      case (r_state)
        LOAD:    w_state_nxt = RUN;
        RUN:     if (w_expire && !r_periodic) w_state_nxt = IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_presc     <= '0;
      r_remaining <= '0;
      r_period    <= '0;
      r_periodic  <= 1'b0;
    end else if (w_accept) begin
      if (w_stop) begin
        r_remaining <= '0;
        r_presc     <= '0;
      end else begin
        r_period   <= (i_cmd_period == '0) ? ONE : i_cmd_period;
        r_periodic <= (i_cmd_mode == 2'b10);
      end
    end else if (r_state == LOAD) begin
      r_remaining <= r_period;
      r_presc     <= '0;
    end else if (r_state == RUN) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      // Reload replaces the final decrement so the count never passes through 0.
      if (w_tick) begin
        if (r_remaining > ONE) r_remaining <= r_remaining - ONE;
        else                   r_remaining <= r_periodic ? r_period : '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_irq     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_expire)       r_irq <= 1'b1;
      else if (i_irq_ack) r_irq <= 1'b0;
      // An ack in the expiry cycle consumes the earlier alarm, so no overrun.
      if (i_irq_ack)               r_overrun <= 1'b0;
      else if (w_expire && r_irq)  r_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hps_alarm_timer.sv
// Bench for hps_alarm_timer: directed scenarios plus randomized traffic against
// an elapsed-time reference model.
module tb_hps_alarm_timer;
  localparam int D   = 3;
  localparam int W   = 16;
  localparam int DP1 = D + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_mode = 2'b00;
  logic [W-1:0] cmd_period = '0;
  logic         irq_ack = 1'b0;
  logic         irq, overrun, busy;
  logic [W-1:0] remaining;

  int checks = 0;
  int errors = 0;

  // Reference model: expiries and remaining derived from edges elapsed since RUN began.
  longint n = 0;
  bit     m_loading, m_running, m_periodic, m_irq, m_ovr;
  int     m_P, m_rem;
  longint m_start;

  always #5 clk = ~clk;

  hps_alarm_timer #(.TICK_DIV(D), .WIDTH(W)) dut (
    .i_clk(clk), .i_reset(reset), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_mode(cmd_mode), .i_cmd_period(cmd_period), .i_irq_ack(irq_ack),
    .o_irq(irq), .o_overrun(overrun), .o_remaining(remaining), .o_busy(busy)
  );

  task automatic model_edge();
    bit acc, stop, exp_now;
    longint el, k;
    n++;
    if (reset) begin
      m_loading = 0; m_running = 0; m_periodic = 0; m_irq = 0; m_ovr = 0;
      m_P = 0; m_rem = 0; m_start = 0;
      return;
    end
    acc  = cmd_valid && !m_loading;
    stop = (cmd_mode == 2'd0) || (cmd_mode == 2'd3);
    exp_now = 0;
    if (m_running && !acc) begin
      el = n - m_start;
      if (el > 0 && (el % (m_P * DP1)) == 0 && (m_periodic || el == m_P * DP1)) exp_now = 1;
    end
    if (irq_ack)              m_ovr = 0;
    else if (exp_now && m_irq) m_ovr = 1;
    if (exp_now)      m_irq = 1;
    else if (irq_ack) m_irq = 0;
    if (acc) begin
      if (stop) begin
        m_loading = 0; m_running = 0; m_rem = 0;
      end else begin
        m_loading = 1; m_running = 0;
        m_P = (cmd_period == 0) ? 1 : int'(cmd_period);
        m_periodic = (cmd_mode == 2'd2);
      end
    end else if (m_loading) begin
      m_loading = 0; m_running = 1; m_start = n; m_rem = m_P;
    end else if (m_running) begin
      k = (n - m_start) / DP1;
      if (m_periodic)    m_rem = m_P - int'(k % m_P);
      else if (k >= m_P) begin m_rem = 0; m_running = 0; end
      else               m_rem = m_P - int'(k);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic steps(input int k);
    repeat (k) step();
  endtask

  task automatic do_reset();
    reset = 1; cmd_valid = 0; irq_ack = 0;
    step();
    reset = 0;
  endtask

  task automatic issue(input logic [1:0] md, input int p);
    cmd_valid = 1; cmd_mode = md; cmd_period = 16'(p);
    step();
    cmd_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({irq, overrun, busy, cmd_ready, remaining} !== {1'b0, 1'b0, 1'b0, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL reset_values: got irq=%b ovr=%b busy=%b rdy=%b rem=%0d want 0 0 0 1 0",
               irq, overrun, busy, cmd_ready, remaining);
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    issue(2'b01, 2);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL oneshot_ready_load: got %b want 0", cmd_ready); end
    step();
    checks++;
    if (remaining !== 16'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL oneshot_E1: got rem=%0d busy=%b want 2 1", remaining, busy);
    end
    steps(4);
    checks++;
    if (remaining !== 16'd1) begin errors++; $display("FAIL oneshot_E5: got rem=%0d want 1", remaining); end
    steps(3);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_E8_irq: got %b want 0", irq); end
    step();
    checks++;
    if (irq !== 1'b1 || busy !== 1'b0 || remaining !== 16'd0) begin
      errors++; $display("FAIL oneshot_E9: got irq=%b busy=%b rem=%0d want 1 0 0", irq, busy, remaining);
    end
    steps(5);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_sticky: got %b want 1", irq); end
    irq_ack = 1; step(); irq_ack = 0;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_ack: got %b want 0", irq); end
  endtask

  task automatic test_periodic_ack();
    int  rises[$];
    bit  prev = 0;
    int  ovr_bad = 0, busy_bad = 0;
    do_reset();
    issue(2'b10, 3);
    for (int e = 1; e <= 40; e++) begin
      step();
      if (irq === 1'b1 && !prev) rises.push_back(e);
      prev = (irq === 1'b1);
      irq_ack = (irq === 1'b1);
      if (overrun !== 1'b0) ovr_bad++;
      if (busy !== 1'b1) busy_bad++;
    end
    irq_ack = 0;
    checks++;
    if (rises.size() != 3 || rises[0] != 13 || rises[1] != 25 || rises[2] != 37) begin
      errors++; $display("FAIL periodic_rises: got %p want '{13,25,37}", rises);
    end
    checks++;
    if (ovr_bad != 0) begin errors++; $display("FAIL periodic_overrun: got %0d cycles set want 0", ovr_bad); end
    checks++;
    if (busy_bad != 0) begin errors++; $display("FAIL periodic_busy: got %0d idle cycles want 0", busy_bad); end
  endtask

  task automatic test_overrun_stop();
    do_reset();
    issue(2'b10, 1);
    steps(4);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL ovr_E4_irq: got %b want 0", irq); end
    step();
    checks++;
    if (irq !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_E5: got irq=%b ovr=%b want 1 0", irq, overrun);
    end
    steps(3);
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_E8: got %b want 0", overrun); end
    step();
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_E9: got %b want 1", overrun); end
    issue(2'b00, 7);
    checks++;
    if (busy !== 1'b0 || remaining !== 16'd0 || irq !== 1'b1 || overrun !== 1'b1) begin
      errors++; $display("FAIL stop_cmd: got busy=%b rem=%0d irq=%b ovr=%b want 0 0 1 1",
                         busy, remaining, irq, overrun);
    end
    irq_ack = 1; step(); irq_ack = 0;
    checks++;
    if (irq !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL single_ack: got irq=%b ovr=%b want 0 0", irq, overrun);
    end
  endtask

  task automatic test_ack_collision();
    do_reset();
    issue(2'b10, 1);
    steps(8);
    irq_ack = 1; step(); irq_ack = 0;
    checks++;
    if (irq !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL ack_collision: got irq=%b ovr=%b want 1 0", irq, overrun);
    end
    steps(4);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_after_collision: got %b want 1", overrun); end
  endtask

  task automatic test_restart();
    int seen = 0;
    do_reset();
    issue(2'b01, 3);
    steps(6);
    issue(2'b01, 5);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL restart_ready_load: got %b want 0", cmd_ready); end
    step();
    checks++;
    if (cmd_ready !== 1'b1 || remaining !== 16'd5) begin
      errors++; $display("FAIL restart_run: got rdy=%b rem=%0d want 1 5", cmd_ready, remaining);
    end
    for (int i = 0; i < 19; i++) begin
      step();
      if (irq !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL restart_old_expiry: got %0d irq cycles want 0", seen); end
    step();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL restart_new_expiry: got %b want 1", irq); end
  endtask

  task automatic test_cmd_vs_expiry();
    do_reset();
    issue(2'b10, 1);
    steps(4);
    issue(2'b01, 2);
    checks++;
    if (irq !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL cmd_wins: got irq=%b rdy=%b want 0 0", irq, cmd_ready);
    end
    step();
    checks++;
    if (remaining !== 16'd2) begin errors++; $display("FAIL cmd_wins_rem: got %0d want 2", remaining); end
    steps(8);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL cmd_wins_expiry: got %b want 1", irq); end
  endtask

  task automatic test_period_zero();
    do_reset();
    issue(2'b01, 0);
    step();
    checks++;
    if (remaining !== 16'd1) begin errors++; $display("FAIL p0_rem: got %0d want 1", remaining); end
    steps(3);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL p0_early: got %b want 0", irq); end
    step();
    checks++;
    if (irq !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL p0_expiry: got irq=%b busy=%b want 1 0", irq, busy);
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    issue(2'b10, 1);
    steps(6);
    checks++;
    if (irq !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL midrun_pre: got irq=%b busy=%b want 1 1", irq, busy);
    end
    reset = 1; step(); reset = 0;
    checks++;
    if ({irq, overrun, busy, cmd_ready, remaining} !== {1'b0, 1'b0, 1'b0, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL midrun_reset: got irq=%b ovr=%b busy=%b rdy=%b rem=%0d want 0 0 0 1 0",
               irq, overrun, busy, cmd_ready, remaining);
    end
  endtask

  task automatic test_random();
    logic [W+3:0] exp_v, got_v;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 399) == 0);
      cmd_valid  = ($urandom_range(0, 11) == 0);
      cmd_mode   = 2'($urandom_range(0, 3));
      cmd_period = 16'($urandom_range(0, 5));
      irq_ack    = ($urandom_range(0, 7) == 0);
      step();
      exp_v = {m_irq, m_ovr, (m_running || m_loading), !m_loading, 16'(m_rem)};
      got_v = {irq, overrun, busy, cmd_ready, remaining};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL random_cycle%0d: got irq/ovr/busy/rdy/rem=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                 i, irq, overrun, busy, cmd_ready, remaining,
                 exp_v[W+3], exp_v[W+2], exp_v[W+1], exp_v[W], exp_v[W-1:0]);
      end
    end
    reset = 0; cmd_valid = 0; irq_ack = 0;
  endtask

  initial begin
    #2;
    test_reset();
    test_oneshot();
    test_periodic_ack();
    test_overrun_stop();
    test_ack_collision();
    test_restart();
    test_cmd_vs_expiry();
    test_period_zero();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hps_alarm_timer.md
# hps_alarm_timer

Programmable alarm timer driven by the HPS, the HPS-to-FPGA counterpart of the free-running HPS timestamp counter. The HPS issues a command with a period in ticks and a mode, and the block counts down using the same tick base: one tick every TICK_DIV+1 clocks. When the count expires, the block raises a level interrupt that the HPS acknowledges. It sits in the GHRD fabric between the HPS lightweight-bridge PIO registers and the HPS interrupt input.

## Interface
- TICK_DIV, 5000: prescaler terminal count; one tick every TICK_DIV+1 clk cycles.
- WIDTH, 32: width of period and remaining count.
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  HPS presents a command.
- cmd_ready  output  1  block can accept a command.
- cmd_mode  input  2  00 stop, 01 one-shot, 10 periodic, 11 reserved (treated as stop).
- cmd_period  input  WIDTH  alarm period in ticks; 0 is treated as 1.
- irq_ack  input  1  HPS clears the interrupt; one-cycle pulse or level.
- irq  output  1  alarm interrupt, level, sticky until acknowledged.
- overrun  output  1  an expiry occurred while irq was already set.
- remaining  output  WIDTH  ticks left before the next expiry.
- busy  output  1  high while the block is armed (state not IDLE).

## Operation
- States: IDLE, LOAD, RUN.
- cmd_ready = (state != LOAD). A command is accepted on any edge with cmd_valid & cmd_ready.
- Accepting a stop command (mode 00 or 11): next state IDLE, remaining <= 0, prescaler <= 0. irq and overrun are unchanged.
- Accepting mode 01 or 10: the period and mode are latched (period 0 is latched as 1), and the next state is LOAD. This is legal from IDLE or RUN; a command in RUN restarts the timer.
- LOAD (1 cycle): remaining <= latched period, prescaler <= 0, next state RUN.
- RUN, prescaler behaviour: the prescaler increments each cycle. When prescaler == TICK_DIV, a tick occurs and the prescaler wraps to 0.
- RUN, on a tick with remaining > 1: remaining <= remaining - 1.
- RUN, on a tick with remaining == 1 (expiry):
  - irq <= 1; if irq is already 1 and irq_ack is not asserted in that cycle, overrun <= 1.
  - Periodic mode: remaining <= latched period, stay in RUN.
  - One-shot mode: remaining <= 0, next state IDLE.
- irq_ack clears irq and overrun on the next edge.
- Simultaneous irq_ack and expiry in the same cycle: irq stays 1 (set wins) and overrun is cleared (the ack consumed the earlier alarm).
- Simultaneous command accept and expiry in RUN: the command wins. No irq is raised, and the new command is processed.
- Arithmetic is unsigned WIDTH-bit. remaining never decrements below 0 or wraps; the reload replaces the decrement.

## Timing
- Reset values (state after the reset edge): state IDLE, irq 0, overrun 0, remaining 0, busy 0, prescaler 0, cmd_ready 1.
- Reset asserted mid-RUN aborts the countdown and drops irq on the same edge.
- All outputs are registered except cmd_ready and busy, which are decoded directly from the state register.
- Let E0 be the accept edge:
  - LOAD holds after E0; RUN starts at E1 with remaining = P.
  - The first decrement occurs at edge E1+(TICK_DIV+1).
  - irq rises at edge E1 + P·(TICK_DIV+1).
- Periodic expiries then repeat every P·(TICK_DIV+1) cycles with no drift.
- irq falls at the edge after irq_ack is sampled high.

## Test plan
- TICK_DIV=3, one-shot P=2 accepted at E0 -> remaining is 2 at E1 and 1 at E5. irq=1 and busy=0 from E9; irq stays high until ack, then is 0 one edge after irq_ack.
- TICK_DIV=3, periodic P=3, ack each irq -> irq rises at E13, E25, E37 (12-cycle spacing), overrun stays 0, busy stays 1.
- TICK_DIV=3, periodic P=1, no ack -> irq rises at E5, and overrun=1 from E9. A single irq_ack clears both irq and overrun.
- irq_ack asserted in the same cycle as an expiry with irq already 1 -> irq remains 1 and overrun=0 after the edge.
- Restart and stop:
  - New one-shot P=5 issued mid-RUN -> cmd_ready=0 for exactly one cycle, remaining=5 the cycle after LOAD, and the old expiry never fires.
  - Stop command -> busy=0 and remaining=0 next edge; irq unchanged.
- Corner cases:
  - Period 0 -> behaves as P=1.
  - Reset pulse while irq=1 and in RUN -> all outputs return to their reset values on that edge.
